// File: rtl/frame_serializer_if.sv
// Handshake and serial-line bundle between an upstream frame controller and frame_serializer.
// The controller side uses the master modport; the serializer uses the slave modport.
interface frame_serializer_if #(
   parameter int LEN_W  = 4,
   parameter int DATA_W = 16
);
   logic              start;
   logic [LEN_W-1:0]  length;
   logic [DATA_W-1:0] data;
   logic              serial_out;
   logic              busy;
   logic              done;

   modport master (
      output start, length, data,
      input  serial_out, busy, done
   );

   modport slave (
      input  start, length, data,
      output serial_out, busy, done
   );
endinterface

// File: rtl/frame_serializer.sv
// Single-wire frame transmitter: preamble 0111110, LEN_W-bit length, then len payload bits MSB first.
// Outputs are registered from next-state values, so the first preamble bit appears right after start is sampled.
module frame_serializer #(
   parameter int LEN_W  = 4,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   frame_serializer_if.slave bus
);
   localparam int CNT_W  = (LEN_W > 3) ? LEN_W : 3;
   localparam int LIDX_W = (LEN_W > 1) ? $clog2(LEN_W) : 1;
   localparam int PIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [6:0] PREAMBLE = 7'b0111110;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      LEN  = 3'd2,
      PAY  = 3'd3,
      FIN  = 3'd4
   } state_t;

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [LEN_W-1:0]  len_r, len_s;
   logic [DATA_W-1:0] shift_r, shift_s;
   logic              serial_r, serial_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic [2:0]        pre_idx_s;
   logic [LIDX_W-1:0] len_idx_s;
   logic [PIDX_W-1:0] pay_idx_s;

   // State, counter, captured frame fields and registered line outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         len_r    <= {LEN_W{1'b0}};
         shift_r  <= {DATA_W{1'b0}};
         serial_r <= 1'b1;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         len_r    <= len_s;
         shift_r  <= shift_s;
         serial_r <= serial_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
      end
   end

   // Next-state sequencing, then the line value that the next state will drive.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      len_s   = len_r;
      shift_s = shift_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_s = PRE;
               cnt_s   = {CNT_W{1'b0}};
               len_s   = bus.length;
               shift_s = bus.data;
            end else begin
               state_s = IDLE;
            end
         end
         PRE: begin
            if (cnt_r == CNT_W'(3'd6)) begin
               state_s = LEN;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_s = cnt_r + CNT_W'(1'b1);
            end
         end
         LEN: begin
            if (cnt_r == CNT_W'(LEN_W - 1)) begin
               cnt_s = {CNT_W{1'b0}};
               if (len_r != {LEN_W{1'b0}}) begin
                  state_s = PAY;
               end else begin
                  state_s = FIN;
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1'b1);
            end
         end
         PAY: begin
            if (cnt_r == CNT_W'(len_r) - CNT_W'(1'b1)) begin
               state_s = FIN;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_s = cnt_r + CNT_W'(1'b1);
            end
         end
         FIN: begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase

      pre_idx_s = 3'd6 - cnt_s[2:0];
      len_idx_s = LIDX_W'(LEN_W - 1) - LIDX_W'(cnt_s);
      pay_idx_s = PIDX_W'(len_s - LEN_W'(1'b1) - LEN_W'(cnt_s));

      serial_s = 1'b1;
      busy_s   = 1'b0;
      done_s   = 1'b0;
      case (state_s)
         PRE: begin
            serial_s = PREAMBLE[pre_idx_s];
            busy_s   = 1'b1;
         end
         LEN: begin
            serial_s = len_s[len_idx_s];
            busy_s   = 1'b1;
         end
         PAY: begin
            serial_s = shift_s[pay_idx_s];
            busy_s   = 1'b1;
         end
         FIN: begin
            done_s = 1'b1;
         end
         IDLE: begin
            serial_s = 1'b1;
         end
         default: begin
            serial_s = 1'b1;
         end
      endcase
   end

   assign bus.serial_out = serial_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
endmodule
